// File: rtl/weight_flusher_pkg.sv
// Shared definitions for the weight flusher and the PE-row weight buffers it feeds.
package weight_flusher_pkg;

    localparam int DATA_WIDTH_DEF   = 16;
    localparam int BUFFER_DEPTH_DEF = 16;
    localparam int NUM_ROWS_DEF     = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_GAP  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    // A burst must fit in one buffer and target at least one existing row.
    function automatic logic cfg_legal(input logic [7:0] ks, input logic [7:0] nr,
                                       input int depth, input int rows);
        return (ks != 8'd0) && (int'(ks) <= depth) &&
               (nr != 8'd0) && (int'(nr) <= rows);
    endfunction

endpackage

// File: rtl/weight_flusher_if.sv
// Valid/ready weight-word stream from the DMA front-end into the flusher.
interface weight_flusher_if #(
    parameter int DATA_WIDTH = 16
);
    logic [DATA_WIDTH-1:0] s_data;
    logic                  s_valid;
    logic                  s_ready;

    modport master (output s_data, output s_valid, input s_ready);
    modport slave  (input s_data, input s_valid, output s_ready);
endinterface

// File: rtl/weight_flusher_flush_burst_counter.sv
// Word-within-row and row counters for the flush bursts, with end-of-row/end-of-job flags.
module flush_burst_counter #(
    parameter int ROW_BITS = 3
) (
    input  logic                clk,
    input  logic                rstn,
    input  logic                i_clr,
    input  logic                i_beat,
    input  logic [7:0]          i_ks,
    input  logic [7:0]          i_nr,
    output logic [ROW_BITS-1:0] o_rc,
    output logic                o_last_word,
    output logic                o_last_row
);
    logic [7:0]          r_wc;
    logic [ROW_BITS-1:0] r_rc;

    assign o_rc        = r_rc;
    assign o_last_word = (r_wc == i_ks - 8'd1);
    assign o_last_row  = (8'(r_rc) == i_nr - 8'd1);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_wc <= '0;
            r_rc <= '0;
        end else if (i_clr) begin
            r_wc <= '0;
            r_rc <= '0;
        end else if (i_beat) begin
            if (o_last_word) begin
                r_wc <= '0;
                // The final row leaves rc alone; the next start clears it.
                if (!o_last_row)
                    r_rc <= r_rc + 1'b1;
            end else begin
                r_wc <= r_wc + 8'd1;
            end
        end
    end

endmodule

// File: rtl/weight_flusher.sv
// Turns a weight-word stream into one-hot flush bursts, kernel_size words per PE-row buffer.
module weight_flusher
    import weight_flusher_pkg::*;
#(
    parameter int DATA_WIDTH   = DATA_WIDTH_DEF,
    parameter int BUFFER_DEPTH = BUFFER_DEPTH_DEF,
    parameter int NUM_ROWS     = NUM_ROWS_DEF,
    parameter int ROW_BITS     = 3
) (
    input  logic                  clk,
    input  logic                  rstn,
    weight_flusher_if.slave       s_if,
    input  logic                  i_start,
    input  logic                  i_abort,
    input  logic [7:0]            i_kernel_size,
    input  logic [7:0]            i_num_rows,
    output logic [NUM_ROWS-1:0]   o_flush,
    output logic [DATA_WIDTH-1:0] o_flush_data,
    output logic                  o_busy,
    output logic                  o_done,
    output logic                  o_err
);
    state_t              r_state;
    state_t              w_next_state;
    logic [7:0]          r_ks;
    logic [7:0]          r_nr;
    logic                w_ready;
    logic                w_beat;
    logic                w_cfg_ok;
    logic                w_start_idle;
    logic                w_accept;
    logic [ROW_BITS-1:0] w_rc;
    logic                w_last_word;
    logic                w_last_row;

    assign w_cfg_ok     = cfg_legal(i_kernel_size, i_num_rows, BUFFER_DEPTH, NUM_ROWS);
    assign w_start_idle = (r_state == ST_IDLE) && i_start && !i_abort;
    assign w_accept     = w_start_idle && w_cfg_ok;
    assign w_beat       = s_if.s_valid && w_ready;
    assign s_if.s_ready = w_ready;

    flush_burst_counter #(
        .ROW_BITS (ROW_BITS)
    ) u_cnt (
        .clk         (clk),
        .rstn        (rstn),
        .i_clr       (w_accept || i_abort),
        .i_beat      (w_beat),
        .i_ks        (r_ks),
        .i_nr        (r_nr),
        .o_rc        (w_rc),
        .o_last_word (w_last_word),
        .o_last_row  (w_last_row)
    );

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)
            r_state <= ST_IDLE;
        else
            r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        w_ready      = 1'b0;
        case (r_state)
            ST_IDLE: if (w_accept) w_next_state = ST_LOAD;
            ST_LOAD: begin
                w_ready = 1'b1;
                if (w_beat && w_last_word)
                    w_next_state = w_last_row ? ST_DONE : ST_GAP;
            end
            ST_GAP:  w_next_state = ST_LOAD;
            ST_DONE: w_next_state = ST_IDLE;
            default: w_next_state = ST_IDLE;
        endcase
        // Abort gates ready in the same cycle so no beat slips through.
        if (i_abort) begin
            w_next_state = ST_IDLE;
            w_ready      = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            o_flush      <= '0;
            o_flush_data <= '0;
            o_busy       <= 1'b0;
            o_done       <= 1'b0;
            o_err        <= 1'b0;
            r_ks         <= '0;
            r_nr         <= '0;
        end else begin
            o_flush <= w_beat ? (NUM_ROWS'(1) << w_rc) : '0;
            if (w_beat)
                o_flush_data <= s_if.s_data;
            o_done <= (r_state == ST_DONE) && !i_abort;
            o_err  <= w_start_idle && !w_cfg_ok;
            if (i_abort || r_state == ST_DONE)
                o_busy <= 1'b0;
            else if (w_accept)
                o_busy <= 1'b1;
            if (w_accept) begin
                r_ks <= i_kernel_size;
                r_nr <= i_num_rows;
            end
        end
    end

endmodule

// File: tb/tb_weight_flusher.sv
// Directed vector table plus hand sequences for abort and async reset of weight_flusher.
module tb_weight_flusher;

    logic       clk = 1'b0;
    logic       rstn;
    logic       start, abort;
    logic [7:0] ks, nr;
    logic [7:0] flush;
    logic [15:0] flush_data;
    logic       busy, done, err;

    int n_cmp = 0;
    int n_bad = 0;

    weight_flusher_if #(.DATA_WIDTH(16)) s_if ();

    weight_flusher dut (
        .clk           (clk),
        .rstn          (rstn),
        .s_if          (s_if),
        .i_start       (start),
        .i_abort       (abort),
        .i_kernel_size (ks),
        .i_num_rows    (nr),
        .o_flush       (flush),
        .o_flush_data  (flush_data),
        .o_busy        (busy),
        .o_done        (done),
        .o_err         (err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        start, abort;
        logic [7:0]  ks, nr;
        logic        valid;
        logic [15:0] data;
        logic        ready;
        logic [7:0]  flush;
        logic [15:0] fdata;
        logic        busy, done, err;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(input logic st, input logic ab, input logic [7:0] k,
                                input logic [7:0] n, input logic vl, input logic [15:0] d,
                                input logic rdy, input logic [7:0] fl, input logic [15:0] fd,
                                input logic bz, input logic dn, input logic er);
        vec_t v;
        v.start = st; v.abort = ab; v.ks = k; v.nr = n; v.valid = vl; v.data = d;
        v.ready = rdy; v.flush = fl; v.fdata = fd; v.busy = bz; v.done = dn; v.err = er;
        vecs.push_back(v);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, want %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        start = 0; abort = 0; s_if.s_valid = 0; s_if.s_data = '0;
    endtask

    initial begin
        int beats;
        idle_inputs();
        ks = 0; nr = 0;
        rstn = 0;
        #12;
        chk("rst_flush", 32'(flush), 0);
        chk("rst_fdata", 32'(flush_data), 0);
        chk("rst_busy",  32'(busy), 0);
        chk("rst_done",  32'(done), 0);
        chk("rst_err",   32'(err), 0);
        chk("rst_ready", 32'(s_if.s_ready), 0);
        #10 rstn = 1;
        step();

        // ks=3 nr=2, valid held high
        add(1,0,3,2,0,'h0,    0,'h00,'h0,1,0,0);
        add(0,0,3,2,1,'h1,    1,'h01,'h1,1,0,0);
        add(0,0,3,2,1,'h2,    1,'h01,'h2,1,0,0);
        add(0,0,3,2,1,'h3,    1,'h01,'h3,1,0,0);
        add(0,0,3,2,1,'h4,    0,'h00,'h3,1,0,0);
        add(0,0,3,2,1,'h4,    1,'h02,'h4,1,0,0);
        add(0,0,3,2,1,'h5,    1,'h02,'h5,1,0,0);
        add(0,0,3,2,1,'h6,    1,'h02,'h6,1,0,0);
        add(0,0,3,2,0,'h0,    0,'h00,'h6,0,1,0);
        add(0,0,3,2,0,'h0,    0,'h00,'h6,0,0,0);
        // ks=4 nr=1, valid toggling
        add(1,0,4,1,0,'h0,    0,'h00,'h6,1,0,0);
        add(0,0,4,1,1,'hA1,   1,'h01,'hA1,1,0,0);
        add(0,0,4,1,0,'hFF,   1,'h00,'hA1,1,0,0);
        add(0,0,4,1,1,'hA2,   1,'h01,'hA2,1,0,0);
        add(0,0,4,1,0,'hFF,   1,'h00,'hA2,1,0,0);
        add(0,0,4,1,1,'hA3,   1,'h01,'hA3,1,0,0);
        add(0,0,4,1,0,'hFF,   1,'h00,'hA3,1,0,0);
        add(0,0,4,1,1,'hA4,   1,'h01,'hA4,1,0,0);
        add(0,0,4,1,0,'h0,    0,'h00,'hA4,0,1,0);
        add(0,0,4,1,0,'h0,    0,'h00,'hA4,0,0,0);
        // illegal configurations
        add(1,0,0,1,0,'h0,    0,'h00,'hA4,0,0,1);
        add(0,0,0,1,0,'h0,    0,'h00,'hA4,0,0,0);
        add(1,0,17,1,0,'h0,   0,'h00,'hA4,0,0,1);
        add(0,0,17,1,0,'h0,   0,'h00,'hA4,0,0,0);
        add(1,0,4,9,0,'h0,    0,'h00,'hA4,0,0,1);
        add(0,0,4,9,0,'h0,    0,'h00,'hA4,0,0,0);
        // start with abort in IDLE: abort wins
        add(1,1,2,1,0,'h0,    0,'h00,'hA4,0,0,0);
        add(0,0,2,1,1,'hEE,   0,'h00,'hA4,0,0,0);
        // max legal config, then abort gates ready in the same cycle
        add(1,0,16,8,0,'h0,   0,'h00,'hA4,1,0,0);
        add(0,1,16,8,1,'hCC,  0,'h00,'hA4,0,0,0);
        add(0,0,16,8,1,'hCC,  0,'h00,'hA4,0,0,0);
        // start while busy and kernel_size changed mid-run
        add(1,0,2,2,0,'h0,    0,'h00,'hA4,1,0,0);
        add(1,0,5,1,1,'hB1,   1,'h01,'hB1,1,0,0);
        add(0,0,7,1,1,'hB2,   1,'h01,'hB2,1,0,0);
        add(1,0,7,1,1,'hB3,   0,'h00,'hB2,1,0,0);
        add(0,0,7,1,1,'hB3,   1,'h02,'hB3,1,0,0);
        add(0,0,7,1,1,'hB4,   1,'h02,'hB4,1,0,0);
        add(1,0,7,1,1,'hB5,   0,'h00,'hB4,0,1,0);
        add(0,0,7,1,0,'h0,    0,'h00,'hB4,0,0,0);

        foreach (vecs[i]) begin
            start = vecs[i].start; abort = vecs[i].abort;
            ks = vecs[i].ks; nr = vecs[i].nr;
            s_if.s_valid = vecs[i].valid; s_if.s_data = vecs[i].data;
            #1;
            chk($sformatf("v%0d_ready", i), 32'(s_if.s_ready), 32'(vecs[i].ready));
            step();
            chk($sformatf("v%0d_flush", i), 32'(flush),      32'(vecs[i].flush));
            chk($sformatf("v%0d_fdata", i), 32'(flush_data), 32'(vecs[i].fdata));
            chk($sformatf("v%0d_busy", i),  32'(busy),       32'(vecs[i].busy));
            chk($sformatf("v%0d_done", i),  32'(done),       32'(vecs[i].done));
            chk($sformatf("v%0d_err", i),   32'(err),        32'(vecs[i].err));
        end
        idle_inputs();
        step();

        // Abort after the 7th beat of a ks=5 nr=3 job
        start = 1; ks = 5; nr = 3;
        step();
        start = 0;
        beats = 0;
        s_if.s_valid = 1;
        for (int c = 0; c < 20 && beats < 7; c++) begin
            s_if.s_data = 16'(beats + 1);
            #1;
            if (s_if.s_ready) beats++;
            step();
        end
        chk("ab_beats", 32'(beats), 7);
        chk("ab_pre_flush", 32'(flush), 'h02);
        chk("ab_pre_fdata", 32'(flush_data), 7);
        abort = 1; s_if.s_data = 16'd8;
        #1;
        chk("ab_ready_gated", 32'(s_if.s_ready), 0);
        step();
        abort = 0;
        chk("ab_flush", 32'(flush), 0);
        chk("ab_fdata", 32'(flush_data), 7);
        chk("ab_busy", 32'(busy), 0);
        for (int c = 0; c < 6; c++) begin
            chk("ab_idle_ready", 32'(s_if.s_ready), 0);
            step();
            chk("ab_idle_flush", 32'(flush), 0);
            chk("ab_idle_done", 32'(done), 0);
        end
        s_if.s_valid = 0;
        start = 1; ks = 2; nr = 1;
        step();
        start = 0;
        s_if.s_valid = 1; s_if.s_data = 16'h51;
        step();
        chk("ab2_w0_flush", 32'(flush), 'h01);
        chk("ab2_w0_fdata", 32'(flush_data), 'h51);
        s_if.s_data = 16'h52;
        step();
        chk("ab2_w1_flush", 32'(flush), 'h01);
        chk("ab2_w1_fdata", 32'(flush_data), 'h52);
        s_if.s_valid = 0;
        step();
        chk("ab2_done", 32'(done), 1);
        chk("ab2_busy", 32'(busy), 0);
        chk("ab2_flush", 32'(flush), 0);
        step();

        // Async reset mid-row
        start = 1; ks = 5; nr = 1;
        step();
        start = 0;
        s_if.s_valid = 1; s_if.s_data = 16'h61;
        step();
        s_if.s_data = 16'h62;
        step();
        chk("rr_pre_flush", 32'(flush), 'h01);
        chk("rr_pre_busy", 32'(busy), 1);
        #1 rstn = 0;
        #1;
        chk("rr_flush", 32'(flush), 0);
        chk("rr_ready", 32'(s_if.s_ready), 0);
        chk("rr_busy", 32'(busy), 0);
        chk("rr_fdata", 32'(flush_data), 0);
        @(negedge clk);
        rstn = 1;
        step();
        start = 1; ks = 1; nr = 8;
        s_if.s_valid = 1;
        step();
        start = 0;
        for (int r = 0; r < 8; r++) begin
            s_if.s_data = 16'(16'h70 + r);
            #1;
            chk($sformatf("k1_r%0d_ready", r), 32'(s_if.s_ready), 1);
            step();
            chk($sformatf("k1_r%0d_flush", r), 32'(flush), 32'(1 << r));
            chk($sformatf("k1_r%0d_fdata", r), 32'(flush_data), 32'(16'h70 + r));
            if (r < 7) begin
                chk($sformatf("k1_gap%0d_ready", r), 32'(s_if.s_ready), 0);
                step();
                chk($sformatf("k1_gap%0d_flush", r), 32'(flush), 0);
            end
        end
        s_if.s_valid = 0;
        chk("k1_done_ready", 32'(s_if.s_ready), 0);
        step();
        chk("k1_done", 32'(done), 1);
        chk("k1_busy", 32'(busy), 0);
        chk("k1_flush", 32'(flush), 0);
        step();
        chk("k1_done_end", 32'(done), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/weight_flusher.md
Name: weight_flusher

Overview:
- Producer side of the weight-buffer flush interface.
- Accepts a valid/ready stream of weight words and writes them as flush write-enable plus data bursts into one weight buffer per PE row.
- Each burst is exactly kernel_size words. A short idle gap separates consecutive rows.
- Sits between the DMA/stream front-end and the PE-array weight buffers. It is the only driver of every buffer's flush and data_in.

Parameters:
- DATA_WIDTH, 16, weight word width.
- BUFFER_DEPTH, 16, capacity of each weight buffer; maximum legal kernel_size.
- NUM_ROWS, 8, number of weight buffers (PE rows) addressable.
- ROW_BITS, 3, width of row select; must equal clog2(NUM_ROWS).

Ports:
- clk  in  1  clock.
- rstn  in  1  reset, asynchronous, active-low.
- start  in  1  single-cycle command pulse; sampled only in IDLE.
- abort  in  1  synchronous cancel; wins over every other event.
- kernel_size  in  8  words per row burst; latched at start.
- num_rows  in  8  number of rows to fill, starting at row 0; latched at start.
- s_data  in  DATA_WIDTH  incoming weight word.
- s_valid  in  1  s_data is valid.
- s_ready  out  1  flusher accepts s_data this cycle.
- flush  out  NUM_ROWS  one-hot write enable; bit r drives buffer r's flush.
- flush_data  out  DATA_WIDTH  word to buffer data_in, shared by all rows.
- busy  out  1  high from accepted start until DONE exits.
- done  out  1  one-cycle pulse when all rows are written.
- err  out  1  one-cycle pulse when a start carries an illegal configuration.

Behaviour:
Reset values:
- s_ready=0, flush=0, flush_data=0, busy=0, done=0, err=0.
- FSM in IDLE; word counter wc=0; row counter rc=0.

States:
- IDLE: s_ready=0.
  - On start with 1<=kernel_size<=BUFFER_DEPTH and 1<=num_rows<=NUM_ROWS: latch ks and nr, clear wc and rc, go to LOAD, set busy=1.
  - On start with an illegal configuration: err=1 for the next cycle only; remain IDLE; busy stays 0.
- LOAD: s_ready=1 combinationally.
  - A beat is s_valid&&s_ready.
  - Each beat registers flush_data<=s_data and flush<=(1<<rc) on the next edge, so latency is 1 cycle from beat to write.
  - Cycles without a beat drive flush=0 on the next edge; flush_data holds its value.
  - A beat with wc==ks-1 sets wc<=0. If rc==nr-1, go to DONE; otherwise rc<=rc+1 and go to GAP.
  - Any other beat sets wc<=wc+1.
- GAP: exactly 1 cycle; s_ready=0; flush=0 on the next edge. This guarantees at least one flush-low cycle between rows so each buffer rewinds its write pointer. Then go to LOAD.
- DONE: s_ready=0; done=1 for the next cycle; busy=0 for the next cycle; go to IDLE.

Invariants:
- Exactly ks consecutive-valid flush cycles per row, in row order 0..nr-1.
- Total writes = ks*nr.
- flush is never multi-hot.

Boundary conditions:
- s_valid low mid-row: bubble cycles with flush=0. The buffer pointer does not advance, and the row stays open.
- ks==1: every beat ends a row, giving the sequence LOAD, GAP, LOAD, ...
- nr==1: no GAP state is ever entered.
- start while busy: ignored; no err.
- start coincident with abort in IDLE: abort wins; start is ignored.
- abort in any state:
  - next edge forces flush=0, s_ready=0, busy=0, wc=0, rc=0, state IDLE;
  - no done pulse.
  - A beat presented in the abort cycle is not accepted, because s_ready is gated low by abort combinationally.
- Async reset mid-burst: all outputs drop immediately to reset values.
- Config inputs may change while busy; only the latched copies are used.

Decomposition:
- Shared package holds:
  - FSM state encoding: IDLE, LOAD, GAP, DONE (2 bits);
  - the legal-config check function;
  - the DATA_WIDTH, BUFFER_DEPTH and NUM_ROWS defaults, shared with the weight buffer.
- One natural sub-module, flush_burst_counter: wc/rc counters with the last_word and last_row flags. The FSM and the output registers stay in the top module.

Test Plan:
- ks=3, nr=2, s_valid held high, data 1..6 -> flush=0x01 for 3 cycles (data 1,2,3), 1 cycle flush=0, flush=0x02 for 3 cycles (data 4,5,6), done pulses once, busy low afterwards, 6 writes total.
- ks=4, nr=1, s_valid toggling 1,0,1,0,... -> exactly 4 flush cycles carrying words in order, with flush=0 in the bubbles; done follows the 4th write; no GAP.
- start with ks=0, then ks=17, then nr=9 -> err pulses each time for one cycle; busy stays 0; flush stays 0.
- ks=5, nr=3, abort asserted after the 7th beat -> no further flush, s_ready=0, done never pulses; a following legal start (ks=2, nr=1) writes row 0 correctly.
- rstn asserted asynchronously mid-row -> flush, s_ready and busy drop within the same cycle; after release, a start (ks=1, nr=8) produces one write per row with rows 0..7 one-hot in order and a gap between each.
- start pulsed again while busy, and kernel_size changed mid-run -> ignored; burst lengths follow the originally latched values.
